// File: rtl/hazard_fwd_scoreboard.sv
// ID-stage hazard unit: per-operand bypass selection across NUM_FWD stages plus a long-latency
// completion bus, a per-register in-flight scoreboard, and a saturating stall-cycle counter.
module hazard_fwd_scoreboard #(
   parameter int unsigned NUM_SRC = 2,
   parameter int unsigned NUM_FWD = 2,
   parameter int unsigned CNT_W   = 32,
   localparam int unsigned SEL_W  = $clog2(NUM_FWD + 2)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NUM_SRC*5-1:0]     src_rs_i,
   input  logic [NUM_SRC-1:0]       src_used_i,
   input  logic [NUM_FWD*5-1:0]     fwd_rd_i,
   input  logic [NUM_FWD-1:0]       fwd_we_i,
   input  logic [NUM_FWD-1:0]       fwd_ready_i,
   input  logic                     issue_valid_i,
   input  logic [4:0]               issue_rd_i,
   input  logic                     issue_long_i,
   input  logic                     lwb_valid_i,
   input  logic [4:0]               lwb_rd_i,
   output logic [NUM_SRC*SEL_W-1:0] fwd_sel_o,
   output logic                     stall_o,
   output logic [31:0]              sb_busy_o,
   output logic [CNT_W-1:0]         stall_cnt_o
);

   logic [31:0]      sb_q, sb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [4:0]       rs;
   logic [SEL_W-1:0] sel;
   logic             matched;
   logic             not_ready;
   logic             hazard;
   logic             waw;

   always_comb begin
      fwd_sel_o = '0;
      hazard    = 1'b0;
      rs        = '0;
      sel       = '0;
      matched   = 1'b0;
      not_ready = 1'b0;
      for (int i = 0; i < int'(NUM_SRC); i++) begin
         rs        = src_rs_i[5*i +: 5];
         sel       = '0;
         matched   = 1'b0;
         not_ready = 1'b0;
         if (src_used_i[i] && rs != 5'd0) begin
            // Walk oldest-to-nearest so the nearest matching stage overwrites the rest.
            for (int k = int'(NUM_FWD) - 1; k >= 0; k--) begin
               if (fwd_we_i[k] && fwd_rd_i[5*k +: 5] == rs) begin
                  sel       = SEL_W'(k + 1);
                  matched   = 1'b1;
                  not_ready = !fwd_ready_i[k];
               end
            end
            if (matched) begin
               hazard = hazard | not_ready;
            end else if (lwb_valid_i && lwb_rd_i == rs) begin
               sel = SEL_W'(NUM_FWD + 1);
            end else if (sb_q[rs]) begin
               hazard = 1'b1;
            end
         end
         fwd_sel_o[SEL_W*i +: SEL_W] = sel;
      end

      waw = issue_long_i && issue_rd_i != 5'd0 && sb_q[issue_rd_i] &&
            !(lwb_valid_i && lwb_rd_i == issue_rd_i);
      stall_o = issue_valid_i && (hazard || waw);
   end

   always_comb begin
      sb_d = sb_q;
      if (lwb_valid_i) begin
         sb_d[lwb_rd_i] = 1'b0;
      end
      // Set after clear: a completion and a fresh issue to the same register leave it busy.
      if (issue_valid_i && issue_long_i && !stall_o && issue_rd_i != 5'd0) begin
         sb_d[issue_rd_i] = 1'b1;
      end
      cnt_d = cnt_q;
      if (stall_o && cnt_q != {CNT_W{1'b1}}) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sb_q  <= '0;
         cnt_q <= '0;
      end else begin
         sb_q  <= sb_d;
         cnt_q <= cnt_d;
      end
   end

   assign sb_busy_o   = sb_q;
   assign stall_cnt_o = cnt_q;

endmodule
